regfile_fwd: RTL and testbench

- General-purpose register file for the 5-stage core: 32x32 storage, one write port driven by the write-back stage, two combinational read ports consumed by ID.
- Receiving end of the EX result interface (write_en/addr/data triple): resolves RAW hazards by forwarding in-flight EX and MEM results to the read ports before they are committed.
- Register 0 is hardwired to zero.

---
 rtl/regfile_fwd.sv | 87 ++++++++
 tb/tb_regfile_fwd.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_fwd.sv
// 32x32 general-purpose register file with WB write-through and, when REGFILE_FWD_EN
// is defined, EX/MEM result forwarding onto both combinational read ports.
module regfile_fwd #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_write_en,
  input  logic [ADDR_W-1:0] wb_write_addr,
  input  logic [DATA_W-1:0] wb_write_data,
  input  logic              ex_write_en,
  input  logic [ADDR_W-1:0] ex_write_addr,
  input  logic [DATA_W-1:0] ex_write_data,
  input  logic              mem_write_en,
  input  logic [ADDR_W-1:0] mem_write_addr,
  input  logic [DATA_W-1:0] mem_write_data,
  input  logic              read_en_1,
  input  logic [ADDR_W-1:0] read_addr_1,
  output logic [DATA_W-1:0] read_data_1,
  input  logic              read_en_2,
  input  logic [ADDR_W-1:0] read_addr_2,
  output logic [DATA_W-1:0] read_data_2,
  output logic [15:0]       write_count
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [15:0]       write_count_q;
  logic [15:0]       write_count_d;
  logic              wb_commit;

  logic              rd_en   [2];
  logic [ADDR_W-1:0] rd_addr [2];
  logic [DATA_W-1:0] rd_data [2];

  always_comb begin
    wb_commit     = wb_write_en && (wb_write_addr != '0);
    regs_d        = regs_q;
    write_count_d = write_count_q;
    if (wb_commit) begin
      regs_d[wb_write_addr] = wb_write_data;
      if (write_count_q != 16'hFFFF) write_count_d = write_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      write_count_q <= '0;
    end else begin
      regs_q        <= regs_d;
      write_count_q <= write_count_d;
    end
  end

  assign rd_en[0]   = read_en_1;
  assign rd_en[1]   = read_en_2;
  assign rd_addr[0] = read_addr_1;
  assign rd_addr[1] = read_addr_2;

  // Later assignments override earlier ones, so the checks run from lowest to highest priority.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_data[p] = regs_q[rd_addr[p]];
      if (wb_write_en && (wb_write_addr == rd_addr[p])) rd_data[p] = wb_write_data;
`ifdef REGFILE_FWD_EN
      if (mem_write_en && (mem_write_addr == rd_addr[p])) rd_data[p] = mem_write_data;
      if (ex_write_en && (ex_write_addr == rd_addr[p])) rd_data[p] = ex_write_data;
`endif
      if (rst || !rd_en[p] || (rd_addr[p] == '0)) rd_data[p] = '0;
    end
  end

`ifndef REGFILE_FWD_EN
  // Forward sources are deliberately ignored in this build; the core stalls on hazards.
  logic unused_fwd;
  assign unused_fwd = ^{ex_write_en, ex_write_addr, ex_write_data,
                        mem_write_en, mem_write_addr, mem_write_data};
`endif

  assign read_data_1 = rd_data[0];
  assign read_data_2 = rd_data[1];
  assign write_count = write_count_q;

endmodule

// File: tb/tb_regfile_fwd.sv
// Scoreboard bench for regfile_fwd: driver pushes reference-model expectations, a
// negedge monitor pops and compares. Model honours REGFILE_FWD_EN like the DUT.
module tb_regfile_fwd;

  logic        clk;
  logic        rst;
  logic        wb_write_en,  ex_write_en,  mem_write_en;
  logic [4:0]  wb_write_addr, ex_write_addr, mem_write_addr;
  logic [31:0] wb_write_data, ex_write_data, mem_write_data;
  logic        read_en_1, read_en_2;
  logic [4:0]  read_addr_1, read_addr_2;
  logic [31:0] read_data_1, read_data_2;
  logic [15:0] write_count;

  regfile_fwd dut (
    .clk(clk), .rst(rst),
    .wb_write_en(wb_write_en), .wb_write_addr(wb_write_addr), .wb_write_data(wb_write_data),
    .ex_write_en(ex_write_en), .ex_write_addr(ex_write_addr), .ex_write_data(ex_write_data),
    .mem_write_en(mem_write_en), .mem_write_addr(mem_write_addr), .mem_write_data(mem_write_data),
    .read_en_1(read_en_1), .read_addr_1(read_addr_1), .read_data_1(read_data_1),
    .read_en_2(read_en_2), .read_addr_2(read_addr_2), .read_data_2(read_data_2),
    .write_count(write_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [15:0] cnt;
    string       tag;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] m_regs [32];
  int          m_cnt;
  int          tests;
  int          fails;
  string       cur_tag;

  function automatic logic [31:0] model_read(input logic en, input logic [4:0] a);
    if (rst || !en || a == 5'd0) return 32'd0;
`ifdef REGFILE_FWD_EN
    if (ex_write_en && ex_write_addr == a) return ex_write_data;
    if (mem_write_en && mem_write_addr == a) return mem_write_data;
`endif
    if (wb_write_en && wb_write_addr == a) return wb_write_data;
    return m_regs[a];
  endfunction

  // One clock: record expectation for the current inputs, then advance the model.
  task automatic cycle();
    exp_t e;
    e.rd1 = model_read(read_en_1, read_addr_1);
    e.rd2 = model_read(read_en_2, read_addr_2);
    e.cnt = 16'(m_cnt);
    e.tag = cur_tag;
    sbq.push_back(e);
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_cnt = 0;
    end else if (wb_write_en && wb_write_addr != 5'd0) begin
      m_regs[wb_write_addr] = wb_write_data;
      if (m_cnt < 65535) m_cnt++;
    end
    #1;
  endtask

  task automatic idle();
    wb_write_en = 0; ex_write_en = 0; mem_write_en = 0;
    read_en_1 = 0; read_en_2 = 0;
  endtask

  task automatic wb(input logic en, input logic [4:0] a, input logic [31:0] d);
    wb_write_en = en; wb_write_addr = a; wb_write_data = d;
  endtask

  task automatic ex(input logic en, input logic [4:0] a, input logic [31:0] d);
    ex_write_en = en; ex_write_addr = a; ex_write_data = d;
  endtask

  task automatic mem(input logic en, input logic [4:0] a, input logic [31:0] d);
    mem_write_en = en; mem_write_addr = a; mem_write_data = d;
  endtask

  task automatic rd(input logic e1, input logic [4:0] a1, input logic e2, input logic [4:0] a2);
    read_en_1 = e1; read_addr_1 = a1; read_en_2 = e2; read_addr_2 = a2;
  endtask

  task automatic randomize_inputs(input int max_addr);
    wb($urandom_range(0, 1), 5'($urandom_range(0, max_addr)), $urandom);
    ex($urandom_range(0, 1), 5'($urandom_range(0, max_addr)), $urandom);
    mem($urandom_range(0, 1), 5'($urandom_range(0, max_addr)), $urandom);
    rd($urandom_range(0, 3) != 0, 5'($urandom_range(0, max_addr)),
       $urandom_range(0, 3) != 0, 5'($urandom_range(0, max_addr)));
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        tests++;
        if (read_data_1 !== e.rd1) begin
          fails++;
          $display("FAIL %s read_data_1 got %h expected %h", e.tag, read_data_1, e.rd1);
        end
        tests++;
        if (read_data_2 !== e.rd2) begin
          fails++;
          $display("FAIL %s read_data_2 got %h expected %h", e.tag, read_data_2, e.rd2);
        end
        tests++;
        if (write_count !== e.cnt) begin
          fails++;
          $display("FAIL %s write_count got %h expected %h", e.tag, write_count, e.cnt);
        end
      end
    end
  end

  initial begin : driver
    int guard;
    tests = 0; fails = 0; m_cnt = 0;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    rst = 1;
    idle();
    wb(0, 0, 0); ex(0, 0, 0); mem(0, 0, 0); rd(0, 0, 0, 0);
    @(posedge clk); #1;

    cur_tag = "reset_hold";
    rd(1, 5'd3, 1, 5'd4);
    cycle();
    rst = 0;

    cur_tag = "prefill";
    for (int i = 0; i < 20; i++) begin
      randomize_inputs(31);
      cycle();
    end
    cur_tag = "reset_clear";
    idle(); rst = 1;
    rd(1, 5'd1, 1, 5'd2);
    cycle();
    rst = 0;
    for (int i = 0; i < 32; i++) begin
      idle(); rd(1, 5'(i), 1, 5'(31 - i));
      cycle();
    end
    cur_tag = "reset_drops_wb";
    idle(); rst = 1; wb(1, 5'd5, 32'hDEADBEEF);
    cycle();
    rst = 0; idle(); rd(1, 5'd5, 1, 5'd5);
    cycle();

    cur_tag = "basic_write";
    idle(); wb(1, 5'd3, 32'h1234_5678);
    cycle();
    idle(); rd(1, 5'd3, 1, 5'd3);
    cycle();
    cur_tag = "write_r0";
    idle(); wb(1, 5'd0, 32'hFFFF_FFFF);
    cycle();
    idle(); rd(1, 5'd0, 1, 5'd0);
    cycle();

    cur_tag = "write_through";
    idle(); wb(1, 5'd7, 32'hA5A5_A5A5); rd(1, 5'd7, 0, 5'd0);
    cycle();
    idle(); rd(1, 5'd7, 1, 5'd7);
    cycle();

    cur_tag = "fwd_priority";
    idle(); wb(1, 5'd9, 32'd1);
    cycle();
    idle(); wb(1, 5'd9, 32'd2); mem(1, 5'd9, 32'd3); ex(1, 5'd9, 32'd4); rd(1, 5'd9, 1, 5'd9);
    cycle();
    ex(0, 5'd9, 32'd4);
    cycle();
    mem(0, 5'd9, 32'd3);
    cycle();

    cur_tag = "gating";
    idle(); ex(1, 5'd9, 32'h77); rd(1, 5'd9, 0, 5'd9);
    cycle();
    idle(); ex(1, 5'd0, 32'h5); mem(1, 5'd0, 32'h6); wb(1, 5'd0, 32'h7); rd(1, 5'd0, 1, 5'd0);
    cycle();

    cur_tag = "random_hazards";
    for (int i = 0; i < 600; i++) begin
      randomize_inputs((i % 2 == 0) ? 3 : 31);
      cycle();
    end

    cur_tag = "saturation";
    idle();
    while (m_cnt < 65535 + 3) begin
      wb(1, 5'($urandom_range(1, 31)), $urandom);
      rd(1, 5'($urandom_range(0, 31)), 1, 5'($urandom_range(0, 31)));
      cycle();
      if (m_cnt == 65535) begin
        for (int k = 0; k < 3; k++) begin
          wb(1, 5'($urandom_range(1, 31)), $urandom);
          cycle();
        end
        break;
      end
    end
    idle(); rd(1, 5'd1, 1, 5'd2);
    cycle();
    cur_tag = "saturation_reset";
    rst = 1;
    cycle();
    rst = 0;
    cycle();

    guard = 0;
    while (sbq.size() > 0 && guard < 10) begin
      @(negedge clk); #1;
      guard++;
    end
    tests++;
    if (sbq.size() != 0) begin
      fails++;
      $display("FAIL drain scoreboard left %0d expected 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
